e203_itcm_ram_ctrl: RTL
=======================

Name: e203_itcm_ram_ctrl

Overview:
- ICB-to-SRAM adapter that sits directly upstream of the ITCM RAM macro wrapper.
- Accepts single-beat 32-bit ICB commands, maps them onto the 64-bit RAM (cs/we/addr/wem/din), and captures 64-bit dout one cycle later. It selects the addressed 32-bit lane and returns it on the ICB response channel, holding it under backpressure.
- Also drives the RAM light-sleep (ls) pin after a programmable idle period. sd/ds are driven 0.

Parameters:
- AW, 16, ICB byte-address width used (64 KiB ITCM).
- RAM_AW, 13, RAM word-address width (AW-3).
- RAM_DW, 64, RAM data width.
- RAM_MW, 8, RAM byte-write-mask width.
- LS_IDLE, 8, consecutive idle cycles before ls asserts (1..255; 0 disables ls).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command accepted when valid&ready
- icb_cmd_addr  in  32  byte address; bits [AW-1:2] used
- icb_cmd_read  in  1  1=read, 0=write
- icb_cmd_wdata  in  32  write data
- icb_cmd_wmask  in  4  byte write enables
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response accepted
- icb_rsp_err  out  1  address out of range
- icb_rsp_rdata  out  32  read data (0 for writes/errors)
- ram_cs  out  1  RAM chip select
- ram_we  out  1  RAM write enable
- ram_addr  out  RAM_AW  RAM word address
- ram_wem  out  RAM_MW  RAM byte mask
- ram_din  out  RAM_DW  RAM write data
- ram_dout  in  RAM_DW  RAM read data, valid cycle after cs
- ram_sd  out  1  tied 0
- ram_ds  out  1  tied 0
- ram_ls  out  1  light sleep

Behaviour:
- Reset values: icb_rsp_valid=0, icb_rsp_err=0, icb_rsp_rdata=0, ram_ls=0, idle counter=0, hold register empty. Reset applies asynchronously mid-transaction; any in-flight response is dropped.
- Power state FSM, states AWAKE and SLEEP:
  - AWAKE->SLEEP when idle_cnt==LS_IDLE-1 and the cycle is idle. Idle means no cmd handshake and rsp_valid=0.
  - SLEEP->AWAKE on icb_cmd_valid=1.
  - ram_ls = (state==SLEEP), registered.
- icb_cmd_ready = (state==AWAKE) & (~icb_rsp_valid | icb_rsp_ready). In SLEEP, cmd_ready=0, so a command arriving in SLEEP costs one wake cycle.
- idle_cnt: increments on idle cycles in AWAKE, saturates at LS_IDLE-1, clears on any handshake or pending response.
- On handshake, the RAM is driven combinationally in the same cycle:
  - in range (addr[31:AW]==0): ram_cs=1, ram_we=~icb_cmd_read, ram_addr=addr[AW-1:3], ram_din={wdata,wdata}.
  - ram_wem = addr[2] ? {wmask,4'b0} : {4'b0,wmask}; all zeros for reads.
  - out of range: ram_cs=0, error flagged.
  - Otherwise ram_cs=0, ram_we=0 (addr/din don't-care).
- Latency: response valid the cycle after the handshake. Registered side-band: is_read, lane=addr[2], err.
- rdata:
  - read, no error: lane ? dout[63:32] : dout[31:0].
  - write or error: 0.
- Backpressure: in the first response cycle, rdata comes from ram_dout directly and is also captured into a 32-bit hold register. Later stalled cycles present the hold register, so data stays stable regardless of dout.
- Back-to-back: rsp handshake and new cmd handshake in the same cycle is allowed, giving 1 transaction/cycle throughput.
- Write followed immediately by a read to the same word returns the new data; this is handled by the RAM's ordering, with no bypass in this block.
- At most one outstanding response.

Decomposition:
- Shared package: ICB field widths, ITCM AW/RAM_AW/RAM_DW/RAM_MW constants, FSM state encodings.
- One natural sub-module: e203_itcm_ls_ctrl (idle counter plus AWAKE/SLEEP FSM), outputting ram_ls and a wake stall.

Test Plan:
- Write addr 0x0000_0004, wdata 0xDEADBEEF, wmask 0xF -> ram_cs=1, ram_we=1, ram_addr=0, ram_wem=0xF0, ram_din=0xDEADBEEF_DEADBEEF. Response next cycle: err=0, rdata=0.
- Read 0x0000_0004 after that write -> rsp_valid 1 cycle after handshake, rdata=0xDEADBEEF. Read 0x0000_0000 -> lower lane.
- Read with icb_rsp_ready=0 for 3 cycles while the bench corrupts ram_dout -> rdata stays at the captured value, cmd_ready=0 throughout, rsp retires when ready=1.
- Address 0x0001_0000 -> ram_cs stays 0, rsp_err=1, rdata=0.
- LS_IDLE=8 with no traffic -> ram_ls=1 after 8 idle cycles. Then cmd_valid=1 -> cmd_ready=0 for 1 cycle, ls=0, handshake on the next cycle.
- Continuous reads with rsp_ready=1 -> one response per cycle. Assert rst_n=0 mid-stream -> rsp_valid and ls drop immediately, and no response is issued after release.

Source files
------------

// File: rtl/e203_itcm_ram_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// e203_itcm_ram_ctrl_pkg
// Shared constants and types for the ITCM ICB-to-SRAM adapter:
//   - ICB command/response field widths
//   - ITCM address/data geometry (64 KiB, 64-bit RAM words)
//   - light-sleep power state encoding
//   - byte-lane write-mask helper
// ----------------------------------------------------------------------------
package e203_itcm_ram_ctrl_pkg;

  localparam int ICB_AW = 32;
  localparam int ICB_DW = 32;
  localparam int ICB_MW = 4;

  localparam int ITCM_AW      = 16;
  localparam int ITCM_RAM_AW  = ITCM_AW - 3;
  localparam int ITCM_RAM_DW  = 64;
  localparam int ITCM_RAM_MW  = 8;
  localparam int ITCM_LS_IDLE = 8;

  // Idle counter width; covers LS_IDLE up to 255.
  localparam int LS_CNT_W = 8;

  typedef enum logic {
    LS_AWAKE = 1'b0,
    LS_SLEEP = 1'b1
  } ls_state_e;

  // Place a 4-bit ICB byte mask onto the addressed 32-bit half of a RAM word.
  function automatic logic [ITCM_RAM_MW-1:0] lane_wem(input logic lane,
                                                      input logic [ICB_MW-1:0] wmask);
    return lane ? {wmask, 4'b0000} : {4'b0000, wmask};
  endfunction

endpackage

// File: rtl/e203_itcm_ram_ctrl_if.sv
// ----------------------------------------------------------------------------
// e203_itcm_ram_ctrl_if
// Single-beat ICB command/response channel into the ITCM adapter.
//   master : drives cmd_valid/addr/read/wdata/wmask and rsp_ready
//   slave  : drives cmd_ready and rsp_valid/err/rdata
// ----------------------------------------------------------------------------
interface e203_itcm_ram_ctrl_if;
  import e203_itcm_ram_ctrl_pkg::*;

  logic              icb_cmd_valid;
  logic              icb_cmd_ready;
  logic [ICB_AW-1:0] icb_cmd_addr;
  logic              icb_cmd_read;
  logic [ICB_DW-1:0] icb_cmd_wdata;
  logic [ICB_MW-1:0] icb_cmd_wmask;
  logic              icb_rsp_valid;
  logic              icb_rsp_ready;
  logic              icb_rsp_err;
  logic [ICB_DW-1:0] icb_rsp_rdata;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    output icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    input  icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );

endinterface

// File: rtl/e203_itcm_ram_ctrl_ls_ctrl.sv
// ----------------------------------------------------------------------------
// e203_itcm_ls_ctrl
// Light-sleep controller: counts consecutive idle cycles and puts the RAM
// into light sleep once LS_IDLE of them have passed. A pending command wakes
// the RAM; commands are held off for the wake cycle.
//   clk, rst_n  : clock, async active-low reset
//   cmd_valid   : ICB command request (wake source)
//   cmd_hsk     : command handshake this cycle
//   rsp_valid   : response pending this cycle
//   ram_ls      : RAM light-sleep pin (registered)
//   wake_stall  : high while asleep, blocks command acceptance
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LS_AWAKE | RAM active, commands accepted, idle cycles being counted
// LS_SLEEP | RAM in light sleep, commands held off until next cycle
// ----------------------------------------------------------------------------
module e203_itcm_ls_ctrl
  import e203_itcm_ram_ctrl_pkg::*;
#(
  parameter int LS_IDLE = ITCM_LS_IDLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  input  logic cmd_hsk,
  input  logic rsp_valid,
  output logic ram_ls,
  output logic wake_stall
);

  localparam bit LS_EN = (LS_IDLE != 0);
  // Terminal count of the idle counter; LS_IDLE=0 parks it at zero.
  localparam logic [LS_CNT_W-1:0] CNT_TC = LS_EN ? LS_CNT_W'(LS_IDLE - 1) : '0;

  ls_state_e           state_q, state_d;
  logic [LS_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic                idle;

  assign idle = ~cmd_hsk & ~rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LS_AWAKE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    unique case (state_q)
      LS_AWAKE: begin
        if (!idle) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == CNT_TC) begin
          if (LS_EN) begin
            state_d    = LS_SLEEP;
            idle_cnt_d = '0;
          end
        end else begin
          idle_cnt_d = idle_cnt_q + LS_CNT_W'(1);
        end
      end
      LS_SLEEP: begin
        idle_cnt_d = '0;
        if (cmd_valid) begin
          state_d = LS_AWAKE;
        end
      end
      default: begin
        state_d    = LS_AWAKE;
        idle_cnt_d = '0;
      end
    endcase
  end

  // Both outputs come straight from the state flop, so ls is glitch-free.
  assign ram_ls     = (state_q == LS_SLEEP);
  assign wake_stall = (state_q == LS_SLEEP);

endmodule

// File: rtl/e203_itcm_ram_ctrl.sv
// ----------------------------------------------------------------------------
// e203_itcm_ram_ctrl
// ICB-to-SRAM adapter in front of the ITCM RAM macro wrapper. Single-beat
// 32-bit ICB commands are mapped onto the 64-bit RAM in the handshake cycle;
// the addressed 32-bit lane of ram_dout is returned one cycle later and held
// stable under response backpressure. Also drives RAM light sleep.
//   clk, rst_n           : clock, async active-low reset
//   icb (slave)          : ICB command/response channel
//   ram_cs/we/addr/wem   : RAM control, driven combinationally on handshake
//   ram_din              : write data replicated to both 32-bit halves
//   ram_dout             : RAM read data, valid the cycle after cs
//   ram_sd/ram_ds        : shutdown/deep sleep, tied off
//   ram_ls               : light sleep after LS_IDLE idle cycles
// ----------------------------------------------------------------------------
module e203_itcm_ram_ctrl
  import e203_itcm_ram_ctrl_pkg::*;
#(
  parameter int AW      = ITCM_AW,
  parameter int RAM_AW  = ITCM_RAM_AW,
  parameter int RAM_DW  = ITCM_RAM_DW,
  parameter int RAM_MW  = ITCM_RAM_MW,
  parameter int LS_IDLE = ITCM_LS_IDLE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  e203_itcm_ram_ctrl_if.slave   icb,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [RAM_MW-1:0]     ram_wem,
  output logic [RAM_DW-1:0]     ram_din,
  input  logic [RAM_DW-1:0]     ram_dout,
  output logic                  ram_sd,
  output logic                  ram_ds,
  output logic                  ram_ls
);

  logic              wake_stall;
  logic              cmd_ready;
  logic              cmd_hsk;
  logic              rsp_hsk;
  logic              in_range;

  logic              rsp_valid_q;
  logic              is_read_q;
  logic              lane_q;
  logic              err_q;
  logic              first_q;
  logic [ICB_DW-1:0] hold_q;
  logic [ICB_DW-1:0] dout_lane;
  logic [ICB_DW-1:0] rsp_data;

  // Word-aligned accesses only; the byte offset carries no information.
  logic              unused_addr_lsb;
  assign unused_addr_lsb = ^icb.icb_cmd_addr[1:0];

  assign in_range  = (icb.icb_cmd_addr[ICB_AW-1:AW] == '0);
  assign cmd_ready = ~wake_stall & (~rsp_valid_q | icb.icb_rsp_ready);
  assign cmd_hsk   = icb.icb_cmd_valid & cmd_ready;
  assign rsp_hsk   = rsp_valid_q & icb.icb_rsp_ready;

  assign icb.icb_cmd_ready = cmd_ready;

  // RAM side: the access is issued in the handshake cycle itself.
  assign ram_cs   = cmd_hsk & in_range;
  assign ram_we   = ram_cs & ~icb.icb_cmd_read;
  assign ram_addr = icb.icb_cmd_addr[AW-1:3];
  assign ram_wem  = ram_we ? lane_wem(icb.icb_cmd_addr[2], icb.icb_cmd_wmask) : '0;
  assign ram_din  = {2{icb.icb_cmd_wdata}};
  assign ram_sd   = 1'b0;
  assign ram_ds   = 1'b0;

  // Response side-band. first_q marks the cycle in which ram_dout still
  // belongs to this access; afterwards the RAM output may be reused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      is_read_q   <= 1'b0;
      lane_q      <= 1'b0;
      err_q       <= 1'b0;
      first_q     <= 1'b0;
      hold_q      <= '0;
    end else begin
      if (cmd_hsk) begin
        rsp_valid_q <= 1'b1;
        is_read_q   <= icb.icb_cmd_read;
        lane_q      <= icb.icb_cmd_addr[2];
        err_q       <= ~in_range;
        first_q     <= 1'b1;
      end else if (rsp_hsk) begin
        rsp_valid_q <= 1'b0;
        first_q     <= 1'b0;
      end else begin
        first_q     <= 1'b0;
      end

      if (rsp_valid_q && first_q) begin
        hold_q <= dout_lane;
      end
    end
  end

  assign dout_lane = lane_q ? ram_dout[RAM_DW-1 -: ICB_DW] : ram_dout[ICB_DW-1:0];
  assign rsp_data  = first_q ? dout_lane : hold_q;

  assign icb.icb_rsp_valid = rsp_valid_q;
  assign icb.icb_rsp_err   = rsp_valid_q & err_q;
  assign icb.icb_rsp_rdata = (rsp_valid_q & is_read_q & ~err_q) ? rsp_data : '0;

  e203_itcm_ls_ctrl #(
    .LS_IDLE (LS_IDLE)
  ) u_ls_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (icb.icb_cmd_valid),
    .cmd_hsk    (cmd_hsk),
    .rsp_valid  (rsp_valid_q),
    .ram_ls     (ram_ls),
    .wake_stall (wake_stall)
  );

endmodule
